// File: rtl/skid_reg_pkg.sv
// Shared types for the skid_reg two-entry pipeline register.
// Holds the occupancy state encoding used by the top-level FSM.
package skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_reg_if.sv
// Valid/ready handshake bundle for skid_reg (producer side and reader side).
// The flush signal exists only when SKID_REG_FLUSH_EN is defined.
interface skid_reg_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SKID_REG_FLUSH_EN
  logic             flush;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
`ifdef SKID_REG_FLUSH_EN
    output flush,
`endif
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
`ifdef SKID_REG_FLUSH_EN
    input  flush,
`endif
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/skid_reg_slot.sv
// Single data slot of skid_reg: a WIDTH-bit register with load enable
// and asynchronous active-low reset to RESET_VAL.
module skid_reg_slot #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/skid_reg.sv
// Two-entry skid register: main slot drives out_data, skid slot absorbs one
// beat so in_ready is decoded from state flops only. Option: SKID_REG_FLUSH_EN.
import skid_reg_pkg::*;

module skid_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  skid_reg_if.slave  bus
);

  skid_state_e      r_state;
  skid_state_e      w_next;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_load;
  logic             w_main_from_skid;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign bus.in_ready  = (r_state != ST_FULL);
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_data  = w_main_q;

  assign w_in_fire  = bus.in_valid  & bus.in_ready;
  assign w_out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_load = 1'b1;
          w_next      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_skid_load = 1'b1;
          w_next      = ST_FULL;
        end else if (w_out_fire) begin
          w_next      = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_next           = ST_BUSY;
        end
      end
      default: begin
        w_next = ST_EMPTY;
      end
    endcase
`ifdef SKID_REG_FLUSH_EN
    // Flush wins over any fire this cycle; slots keep their stale contents.
    if (bus.flush) begin
      w_next           = ST_EMPTY;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
    end
`endif
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : bus.in_data;

  skid_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  skid_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_skid_load),
    .i_d    (bus.in_data),
    .o_q    (w_skid_q)
  );

endmodule
